// File: rtl/scp_fetch_unit.sv
// scp_fetch_unit: program counter, variable-latency instruction fetch and
// next-PC selection feeding the main decoder/controller.
module scp_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        Branch,
  input  logic        Jump,
  output logic        instr_valid,
  output logic [5:0]  opCode,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [5:0]  func,
  output logic [15:0] imm16,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        halted
);

  typedef enum logic [1:0] {S_FETCH, S_EXEC, S_HALT} state_t;

  state_t      state;
  logic [31:0] pc_q;
  logic [31:0] ir_q;
  logic        req_q;
  logic        valid_q;
  logic        halted_q;
  logic [31:0] seq_pc;
  logic [31:0] next_pc;
  logic [31:0] ir_out;

  // Word-aligned sign-extended branch displacement.
  function automatic logic signed [31:0] branch_offset(input logic [15:0] imm);
    branch_offset = {{14{imm[15]}}, imm, 2'b00};
  endfunction

  assign seq_pc = pc_q + 32'd4;

  // Next-PC selection: jump wins over branch, branch over sequential.
  always_comb begin
    next_pc = seq_pc;
    if (Jump) begin
      next_pc = {seq_pc[31:28], ir_q[25:0], 2'b00};
    end else if (Branch) begin
      next_pc = seq_pc + branch_offset(ir_q[15:0]);
    end
  end

  // Fetch/execute/halt sequencer with registered request, valid and halt flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_FETCH;
      pc_q     <= RESET_PC;
      ir_q     <= 32'd0;
      req_q    <= 1'b1;
      valid_q  <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      case (state)
        S_FETCH: begin
          if (imem_ack) begin
            ir_q  <= imem_rdata;
            req_q <= 1'b0;
            if (imem_rdata == HALT_WORD) begin
              state    <= S_HALT;
              halted_q <= 1'b1;
            end else begin
              state   <= S_EXEC;
              valid_q <= 1'b1;
            end
          end
        end
        S_EXEC: begin
          if (!stall) begin
            pc_q    <= next_pc;
            state   <= S_FETCH;
            req_q   <= 1'b1;
            valid_q <= 1'b0;
          end
        end
        default: begin
          state    <= S_HALT;
          req_q    <= 1'b0;
          valid_q  <= 1'b0;
          halted_q <= 1'b1;
        end
      endcase
    end
  end

  // While reset is held, suppress handshakes and present the reset view.
  assign imem_req    = req_q & ~rst;
  assign instr_valid = valid_q & ~rst;
  assign halted      = halted_q & ~rst;
  assign pc          = rst ? RESET_PC : pc_q;
  assign pc_plus4    = pc + 32'd4;
  assign imem_addr   = pc;
  assign ir_out      = rst ? 32'd0 : ir_q;

  assign opCode = ir_out[31:26];
  assign rs     = ir_out[25:21];
  assign rt     = ir_out[20:16];
  assign rd     = ir_out[15:11];
  assign func   = ir_out[5:0];
  assign imm16  = ir_out[15:0];

endmodule

// File: tb/tb_scp_fetch_unit.sv
// Directed self-checking bench for scp_fetch_unit.
module tb_scp_fetch_unit;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        Branch;
  logic        Jump;
  logic        instr_valid;
  logic [5:0]  opCode;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [5:0]  func;
  logic [15:0] imm16;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        halted;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] cur_pc;

  scp_fetch_unit dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .stall(stall),
    .Branch(Branch), .Jump(Jump), .instr_valid(instr_valid),
    .opCode(opCode), .rs(rs), .rt(rt), .rd(rd), .func(func),
    .imm16(imm16), .pc(pc), .pc_plus4(pc_plus4), .halted(halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // One instruction: waits ack-wait cycles, stalls EXEC stall cycles,
  // then Branch/Jump applied; nxt is the hand-computed next PC.
  task automatic instr(input logic [31:0] word, input int waits, input int stalls,
                       input logic br, input logic jp, input logic [31:0] nxt);
    for (int w = 0; w < waits; w++) begin
      imem_ack = 1'b0;
      #1;
      chk("wait_req", {31'd0, imem_req}, 32'd1);
      chk("wait_addr", imem_addr, cur_pc);
      chk("wait_valid", {31'd0, instr_valid}, 32'd0);
      tick();
    end
    imem_ack   = 1'b1;
    imem_rdata = word;
    #1;
    chk("ack_req", {31'd0, imem_req}, 32'd1);
    chk("ack_addr", imem_addr, cur_pc);
    chk("ack_valid", {31'd0, instr_valid}, 32'd0);
    tick();
    imem_ack   = 1'b0;
    imem_rdata = 32'hDEAD_BEEF;
    for (int s = 0; s < stalls; s++) begin
      stall  = 1'b1;
      Branch = (s % 2 == 0) ? 1'b1 : 1'b0;
      Jump   = 1'b0;
      #1;
      chk("stall_valid", {31'd0, instr_valid}, 32'd1);
      chk("stall_pc", pc, cur_pc);
      chk("stall_req", {31'd0, imem_req}, 32'd0);
      tick();
    end
    stall  = 1'b0;
    Branch = br;
    Jump   = jp;
    #1;
    chk("exec_valid", {31'd0, instr_valid}, 32'd1);
    chk("exec_req", {31'd0, imem_req}, 32'd0);
    chk("exec_op", {26'd0, opCode}, {26'd0, word[31:26]});
    chk("exec_rs", {27'd0, rs}, {27'd0, word[25:21]});
    chk("exec_rt", {27'd0, rt}, {27'd0, word[20:16]});
    chk("exec_rd", {27'd0, rd}, {27'd0, word[15:11]});
    chk("exec_func", {26'd0, func}, {26'd0, word[5:0]});
    chk("exec_imm", {16'd0, imm16}, {16'd0, word[15:0]});
    chk("exec_pc", pc, cur_pc);
    chk("exec_pc4", pc_plus4, cur_pc + 32'd4);
    tick();
    Branch = 1'b0;
    Jump   = 1'b0;
    cur_pc = nxt;
  endtask

  initial begin
    rst        = 1'b1;
    imem_ack   = 1'b0;
    imem_rdata = 32'd0;
    stall      = 1'b0;
    Branch     = 1'b0;
    Jump       = 1'b0;
    cur_pc     = 32'h0;
    tick();
    tick();
    // Reset state
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_pc", pc, 32'h0);
    chk("rst_pc4", pc_plus4, 32'h4);
    chk("rst_op", {26'd0, opCode}, 32'd0);
    chk("rst_halted", {31'd0, halted}, 32'd0);
    rst = 1'b0;

    // Sequential fetch, zero wait
    instr(32'h0000_0020, 0, 0, 1'b0, 1'b0, 32'h4);
    instr(32'h0000_0022, 0, 0, 1'b0, 1'b0, 32'h8);
    // Three wait cycles
    instr(32'h0123_4567, 3, 0, 1'b0, 1'b0, 32'hC);
    instr(32'h0000_0000, 0, 0, 1'b0, 1'b0, 32'h10);
    // Backward taken branch: 0x14 - 16 = 0x04
    instr(32'h1000_FFFC, 0, 0, 1'b1, 1'b0, 32'h04);
    // Branch 0x08 - 12 = 0xFFFF_FFFC
    instr(32'h1000_FFFD, 0, 0, 1'b1, 1'b0, 32'hFFFF_FFFC);
    // Two stall cycles with Branch toggling, then wrap to 0
    instr(32'h1000_0004, 0, 2, 1'b0, 1'b0, 32'h0000_0000);
    // Jump chain up through the top nibble regions
    for (int k = 0; k < 8; k++) begin
      instr(32'h0BFF_FFFF, 1, 0, 1'b0, 1'b1, (32'(k) << 28) | 32'h0FFF_FFFC);
    end
    instr(32'h0000_0000, 0, 0, 1'b0, 1'b0, 32'h8000_0000);
    // Jump beats Branch
    instr(32'h0800_0040, 0, 0, 1'b1, 1'b1, 32'h8000_0100);
    chk("jump_pc", pc, 32'h8000_0100);

    // Halt word
    imem_ack   = 1'b1;
    imem_rdata = 32'hFFFF_FFFF;
    #1;
    chk("halt_ack_req", {31'd0, imem_req}, 32'd1);
    tick();
    imem_ack = 1'b0;
    for (int h = 0; h < 3; h++) begin
      imem_ack = h[0];
      #1;
      chk("halt_flag", {31'd0, halted}, 32'd1);
      chk("halt_valid", {31'd0, instr_valid}, 32'd0);
      chk("halt_req", {31'd0, imem_req}, 32'd0);
      tick();
    end
    imem_ack = 1'b0;

    // Reset out of halt, then reset mid-fetch with a coincident ack
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("rel_halted", {31'd0, halted}, 32'd0);
    chk("rel_req", {31'd0, imem_req}, 32'd1);
    chk("rel_addr", imem_addr, 32'h0);
    tick();
    rst        = 1'b1;
    imem_ack   = 1'b1;
    imem_rdata = 32'h0000_0020;
    #1;
    chk("midrst_req", {31'd0, imem_req}, 32'd0);
    chk("midrst_valid", {31'd0, instr_valid}, 32'd0);
    tick();
    rst      = 1'b0;
    imem_ack = 1'b0;
    #1;
    chk("restart_req", {31'd0, imem_req}, 32'd1);
    chk("restart_addr", imem_addr, 32'h0);
    chk("restart_valid", {31'd0, instr_valid}, 32'd0);
    chk("restart_func", {26'd0, func}, 32'd0);
    tick();
    cur_pc = 32'h0;
    instr(32'h0000_0022, 0, 0, 1'b0, 1'b0, 32'h4);
    #1;
    chk("final_addr", imem_addr, 32'h4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
